// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and the IM (slave).
// The master raises im_req with a stable im_addr until the slave answers with im_ack.
interface instruction_fetch_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_ack;

    modport master (
        output im_req,
        output im_addr,
        input  im_rdata,
        input  im_ack
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_rdata,
        output im_ack
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the IM over a req/ack bus with a timeout,
// and holds the fetched word for the rest of the multicycle instruction.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] NOP_INSN = 32'h4000_0009
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable_fetch,
    input  logic                       enable_writeback,
    input  logic [1:0]                 pc_select,
    input  logic [13:0]                imm_14bit,
    input  logic [23:0]                imm_24bit,
    instruction_fetch_if.master        bus,
    output logic [31:0]                instruction,
    output logic [31:0]                pc,
    output logic                       fetch_busy,
    output logic                       fetch_done,
    output logic                       fetch_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  wait_count;
    logic [31:0] addr_latch;

    logic        latch_addr;
    logic        load_insn;
    logic        load_nop;
    logic        set_error;
    logic        clear_error;
    logic        count_up;

    logic [31:0] branch_offset;
    logic [31:0] jump_offset;
    logic [31:0] next_pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Misaligned starts skip the bus entirely and go straight to DONE with a NOP.
    always_comb begin
        next_state  = state;
        latch_addr  = 1'b0;
        load_insn   = 1'b0;
        load_nop    = 1'b0;
        set_error   = 1'b0;
        clear_error = 1'b0;
        count_up    = 1'b0;
        case (state)
            IDLE: begin
                if (enable_fetch) begin
                    if (pc[1:0] == 2'b00) begin
                        latch_addr  = 1'b1;
                        clear_error = 1'b1;
                        next_state  = WAIT;
                    end else begin
                        load_nop   = 1'b1;
                        set_error  = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            WAIT: begin
                if (bus.im_ack) begin
                    load_insn  = 1'b1;
                    next_state = DONE;
                end else if (wait_count == LAST_WAIT) begin
                    load_nop   = 1'b1;
                    set_error  = 1'b1;
                    next_state = DONE;
                end else begin
                    count_up = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_count  <= 8'd0;
            addr_latch  <= 32'd0;
            instruction <= 32'd0;
            fetch_error <= 1'b0;
        end else begin
            if (latch_addr) begin
                wait_count <= 8'd0;
                addr_latch <= pc;
            end else if (count_up) begin
                wait_count <= wait_count + 8'd1;
            end
            if (load_insn) begin
                instruction <= bus.im_rdata;
            end else if (load_nop) begin
                instruction <= NOP_INSN;
            end
            if (set_error) begin
                fetch_error <= 1'b1;
            end else if (clear_error) begin
                fetch_error <= 1'b0;
            end
        end
    end

    // Offsets are in halfwords and relative to the branch/jump's own address.
    assign branch_offset = {{17{imm_14bit[13]}}, imm_14bit, 1'b0};
    assign jump_offset   = {{7{imm_24bit[23]}}, imm_24bit, 1'b0};

    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_select)
            2'b01:   next_pc = pc + branch_offset;
            2'b10:   next_pc = pc + jump_offset;
            default: next_pc = pc + 32'd4;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (enable_writeback) begin
            pc <= next_pc;
        end
    end

    assign bus.im_req  = (state == WAIT);
    assign bus.im_addr = addr_latch;
    assign fetch_busy  = (state == WAIT);
    assign fetch_done  = (state == DONE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: the bench plays the instruction memory
// and checks fetch timing, timeout, PC arithmetic and reset behaviour.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        enable_fetch;
    logic        enable_writeback;
    logic [1:0]  pc_select;
    logic [13:0] imm_14bit;
    logic [23:0] imm_24bit;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_error;

    int checks;
    int errors;

    instruction_fetch_if bus();

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (15),
        .NOP_INSN (32'h4000_0009)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable_fetch     (enable_fetch),
        .enable_writeback (enable_writeback),
        .pc_select        (pc_select),
        .imm_14bit        (imm_14bit),
        .imm_24bit        (imm_24bit),
        .bus              (bus.master),
        .instruction      (instruction),
        .pc               (pc),
        .fetch_busy       (fetch_busy),
        .fetch_done       (fetch_done),
        .fetch_error      (fetch_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic writeback(input logic [1:0] sel, input logic [13:0] i14, input logic [23:0] i24);
        pc_select        = sel;
        imm_14bit        = i14;
        imm_24bit        = i24;
        enable_writeback = 1'b1;
        tick();
        enable_writeback = 1'b0;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        enable_fetch     = 1'b0;
        enable_writeback = 1'b0;
        pc_select        = 2'b00;
        imm_14bit        = 14'd0;
        imm_24bit        = 24'd0;
        bus.im_ack       = 1'b0;
        bus.im_rdata     = 32'd0;
        tick();
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_insn: got %h expected %h", instruction, 32'h0); end
        checks++; if (bus.im_req !== 1'b0 || bus.im_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus: req=%b addr=%h expected 0/0", bus.im_req, bus.im_addr); end
        checks++; if ({fetch_busy, fetch_done, fetch_error} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {fetch_busy, fetch_done, fetch_error}); end
        reset = 1'b0;
        tick();
    endtask

    // Fetch from the current pc with the IM acking in the first WAIT cycle.
    task automatic test_fast_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        checks++; if (bus.im_req !== 1'b1 || fetch_busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_wait: req=%b busy=%b expected 1/1", tag, bus.im_req, fetch_busy); end
        checks++; if (bus.im_addr !== exp_addr) begin errors++; $display("[TB] FAIL %s_addr: got %h expected %h", tag, bus.im_addr, exp_addr); end
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL %s_early_done: got %b expected 0", tag, fetch_done); end
        bus.im_ack   = 1'b1;
        bus.im_rdata = word;
        tick();
        bus.im_ack   = 1'b0;
        bus.im_rdata = 32'd0;
        checks++; if (bus.im_req !== 1'b0 || fetch_done !== 1'b1) begin errors++; $display("[TB] FAIL %s_done: req=%b done=%b expected 0/1", tag, bus.im_req, fetch_done); end
        checks++; if (instruction !== word) begin errors++; $display("[TB] FAIL %s_insn: got %h expected %h", tag, instruction, word); end
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("[TB] FAIL %s_error: got %b expected 0", tag, fetch_error); end
        tick();
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL %s_done_width: got %b expected 0", tag, fetch_done); end
    endtask

    task automatic test_slow_ack();
        int req_cycles;
        req_cycles   = 0;
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.im_req === 1'b1) req_cycles++;
            checks++; if (fetch_busy !== 1'b1 || bus.im_addr !== 32'h0 || fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL slow_wait%0d: busy=%b addr=%h done=%b expected 1/0/0", i, fetch_busy, bus.im_addr, fetch_done); end
            enable_fetch = (i == 1);
            if (i == 3) begin
                bus.im_ack   = 1'b1;
                bus.im_rdata = 32'h1234_5678;
            end
            tick();
        end
        enable_fetch = 1'b0;
        bus.im_ack   = 1'b0;
        checks++; if (req_cycles != 4 || bus.im_req !== 1'b0) begin errors++; $display("[TB] FAIL slow_req_cycles: got %0d req=%b expected 4/0", req_cycles, bus.im_req); end
        checks++; if (fetch_done !== 1'b1 || instruction !== 32'h1234_5678) begin errors++; $display("[TB] FAIL slow_done: done=%b insn=%h expected 1/12345678", fetch_done, instruction); end
        tick();
        checks++; if (fetch_busy !== 1'b0 || fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL slow_no_queue: busy=%b done=%b expected 0/0", fetch_busy, fetch_done); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles   = 0;
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        for (int i = 0; i < 20 && bus.im_req === 1'b1; i++) begin
            req_cycles++;
            tick();
        end
        checks++; if (req_cycles != 15) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d expected 15", req_cycles); end
        checks++; if (fetch_done !== 1'b1 || instruction !== 32'h4000_0009 || fetch_error !== 1'b1) begin errors++; $display("[TB] FAIL timeout_abort: done=%b insn=%h err=%b expected 1/40000009/1", fetch_done, instruction, fetch_error); end
        bus.im_ack   = 1'b1;
        bus.im_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        bus.im_ack   = 1'b0;
        bus.im_rdata = 32'd0;
        checks++; if (instruction !== 32'h4000_0009 || fetch_error !== 1'b1 || bus.im_req !== 1'b0) begin errors++; $display("[TB] FAIL timeout_late_ack: insn=%h err=%b req=%b expected 40000009/1/0", instruction, fetch_error, bus.im_req); end
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("[TB] FAIL timeout_error_clear: got %b expected 0", fetch_error); end
        bus.im_ack   = 1'b1;
        bus.im_rdata = 32'hCAFE_0001;
        tick();
        bus.im_ack   = 1'b0;
        checks++; if (instruction !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL timeout_refetch: got %h expected %h", instruction, 32'hCAFE_0001); end
        tick();
    endtask

    task automatic test_writeback();
        writeback(2'b10, 14'd0, 24'h000080);
        checks++; if (pc !== 32'h0000_0100) begin errors++; $display("[TB] FAIL wb_setup: got %h expected %h", pc, 32'h100); end
        writeback(2'b01, 14'h3FFE, 24'd0);
        checks++; if (pc !== 32'h0000_00FC) begin errors++; $display("[TB] FAIL wb_branch_back: got %h expected %h", pc, 32'hFC); end
        writeback(2'b10, 14'd0, 24'h000010);
        checks++; if (pc !== 32'h0000_011C) begin errors++; $display("[TB] FAIL wb_jump: got %h expected %h", pc, 32'h11C); end
        writeback(2'b11, 14'h1FFF, 24'hFFFFFF);
        checks++; if (pc !== 32'h0000_0120) begin errors++; $display("[TB] FAIL wb_sel11: got %h expected %h", pc, 32'h120); end
        writeback(2'b10, 14'd0, 24'hFFFF6E);
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wb_jump_neg: got %h expected %h", pc, 32'hFFFF_FFFC); end
        writeback(2'b00, 14'd0, 24'd0);
        checks++; if (pc !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wb_wrap: got %h expected %h", pc, 32'h0); end
    endtask

    task automatic test_misaligned();
        writeback(2'b01, 14'h0081, 24'd0);
        checks++; if (pc !== 32'h0000_0102) begin errors++; $display("[TB] FAIL mis_branch: got %h expected %h", pc, 32'h102); end
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        checks++; if (bus.im_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL mis_no_req: req=%b busy=%b expected 0/0", bus.im_req, fetch_busy); end
        checks++; if (fetch_done !== 1'b1 || instruction !== 32'h4000_0009 || fetch_error !== 1'b1) begin errors++; $display("[TB] FAIL mis_nop: done=%b insn=%h err=%b expected 1/40000009/1", fetch_done, instruction, fetch_error); end
        tick();
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL mis_done_width: got %b expected 0", fetch_done); end
    endtask

    task automatic test_back_to_back();
        writeback(2'b01, 14'h007F, 24'd0);
        checks++; if (pc !== 32'h0000_0200) begin errors++; $display("[TB] FAIL b2b_setup: got %h expected %h", pc, 32'h200); end
        enable_fetch     = 1'b1;
        enable_writeback = 1'b1;
        pc_select        = 2'b00;
        tick();
        enable_fetch     = 1'b0;
        enable_writeback = 1'b0;
        checks++; if (bus.im_addr !== 32'h0000_0200 || pc !== 32'h0000_0204 || bus.im_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_same_edge: addr=%h pc=%h req=%b expected 200/204/1", bus.im_addr, pc, bus.im_req); end
        writeback(2'b00, 14'd0, 24'd0);
        checks++; if (bus.im_addr !== 32'h0000_0200 || pc !== 32'h0000_0208) begin errors++; $display("[TB] FAIL b2b_wb_in_wait: addr=%h pc=%h expected 200/208", bus.im_addr, pc); end
        bus.im_ack   = 1'b1;
        bus.im_rdata = 32'h0BAD_F00D;
        tick();
        bus.im_ack   = 1'b0;
        checks++; if (fetch_done !== 1'b1 || instruction !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL b2b_capture: done=%b insn=%h expected 1/0badf00d", fetch_done, instruction); end
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        checks++; if (bus.im_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre: req=%b expected 1", bus.im_req); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({bus.im_req, fetch_busy, fetch_done} !== 3'b000) begin errors++; $display("[TB] FAIL rst_mid_async: req/busy/done=%b expected 000", {bus.im_req, fetch_busy, fetch_done}); end
        checks++; if (pc !== 32'h0 || instruction !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_regs: pc=%h insn=%h expected 0/0", pc, instruction); end
        tick();
        reset = 1'b0;
        tick();
        test_fast_fetch("after_rst", 32'h0, 32'h4620_0005);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fast_fetch("first", 32'h0, 32'h4620_0005);
        test_slow_ack();
        test_timeout();
        test_writeback();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream neighbour of the multicycle controller.
- Owns the program counter and issues instruction-memory read requests with a req/ack handshake and a timeout.
- Holds the fetched instruction word steady for decode, execute, memaccess and writeback.
- Applies the next-PC decision (pc_select) on the controller's writeback pulse.
- Exposes busy/done so the controller can stall S0 on a slow IM.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT, 15, max wait cycles for im_ack before a fetch aborts (1..255).
- NOP_INSN, 32'h4000_0009, word loaded into instruction on an aborted or misaligned fetch.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable_fetch  in  1  one-cycle fetch start pulse from the controller.
- enable_writeback  in  1  one-cycle PC update pulse from the controller.
- pc_select  in  2  00 = PC+4, 01 = branch, 10 = jump, 11 = PC+4.
- imm_14bit  in  14  branch offset in halfwords.
- imm_24bit  in  24  jump offset in halfwords.
- im_req  out  1  IM read request.
- im_addr  out  32  IM byte address, latched at fetch start.
- im_rdata  in  32  IM read data, valid while im_ack=1.
- im_ack  in  1  IM read complete.
- instruction  out  32  held instruction register.
- pc  out  32  address of the current instruction.
- fetch_busy  out  1  a fetch is in progress (WAIT state).
- fetch_done  out  1  one-cycle pulse: instruction register just updated.
- fetch_error  out  1  last fetch was aborted; sticky until the next accepted fetch.

Behaviour:
- Reset values:
  - pc = RESET_PC; instruction = 0; im_req = 0; im_addr = 0.
  - fetch_busy = 0; fetch_done = 0; fetch_error = 0.
  - state = IDLE; wait counter = 0.
- Reset asserted mid-fetch abandons the fetch immediately; im_req drops asynchronously.
- FSM states:
  - IDLE:
    - enable_fetch=1 and pc[1:0]==0: im_addr <= pc, counter <= 0, fetch_error <= 0, go to WAIT.
    - enable_fetch=1 and pc[1:0]!=0 (misaligned): no request issued; instruction <= NOP_INSN, fetch_error <= 1, go to DONE.
  - WAIT:
    - im_req=1, fetch_busy=1; im_addr stays stable.
    - im_ack=1: instruction <= im_rdata, go to DONE. An ack in the first WAIT cycle is legal, giving minimum latency of 1 cycle from the start pulse to ack capture.
    - Else counter increments. When counter reaches TIMEOUT-1 with no ack (TIMEOUT WAIT cycles total), instruction <= NOP_INSN, fetch_error <= 1, go to DONE.
    - A late ack arriving after abort is ignored.
  - DONE: fetch_done=1 for exactly one cycle, im_req=0, then go to IDLE.
- Outputs are registered from state (Moore). instruction changes only on the DONE transition.
- enable_fetch while in WAIT or DONE is ignored; it is neither queued nor counted.
- PC update happens on the enable_writeback pulse, in any state. An in-flight fetch is unaffected because im_addr is latched.
  - pc_select 00 or 11: pc <= pc + 4.
  - pc_select 01: pc <= pc + (sign_extend(imm_14bit) << 1).
  - pc_select 10: pc <= pc + (sign_extend(imm_24bit) << 1).
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
  - Offsets are relative to the current pc, i.e. the address of the branch or jump itself.
- Simultaneous enable_fetch and enable_writeback in IDLE: the fetch latches the OLD pc and pc updates the same edge.
- An odd-halfword target (pc[1]=1) is not flagged at writeback; it is caught by the misalignment rule at the next fetch.

Test Plan:
- Reset then pulse enable_fetch with IM acking on the 1st WAIT cycle, rdata=32'h4620_0005 -> im_addr=0, im_req high for 1 cycle, instruction=32'h4620_0005, fetch_done pulses 2 cycles after the start pulse, fetch_error=0.
- IM acks after 4 wait cycles -> im_req high for exactly 4 cycles, im_addr stable, fetch_busy=1 throughout, then fetch_done pulses once.
- No ack with TIMEOUT=15 -> im_req high for 15 cycles, instruction=32'h4000_0009, fetch_error=1. A late ack on cycle 17 leaves instruction unchanged. The next fetch clears fetch_error.
- Writeback sequence from pc=32'h100:
  - pc_select=01, imm_14bit=14'h3FFE -> pc=32'h0FC.
  - then pc_select=10, imm_24bit=24'h000010 -> pc=32'h11C.
  - then pc_select=11 -> pc=32'h120.
- pc=32'hFFFF_FFFC with pc_select=00 -> pc=32'h0000_0000 (wrap). A separate branch leaving pc=32'h102, followed by enable_fetch -> no im_req, NOP loaded, fetch_error=1, fetch_done pulses.
- Assert reset during WAIT -> im_req, fetch_busy and fetch_done are 0 immediately, pc=RESET_PC. A new fetch after reset release behaves as in the first scenario.
